// File: rtl/memoredf_pkg.sv
// Shared types for the transaction dispatcher: FSM state encoding and
// queue-id width helper.
package memoredf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dispatcher_state_t;

  // A single queue still needs a 1-bit id port.
  function automatic int qid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transaction_dispatcher_dispatch_stats.sv
// Per-queue accepted-packet counters plus the drop counter; all wrap freely.
module dispatch_stats
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int QW               = qid_width(NUMBER_OF_QUEUES)
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             inc_dispatch,
  input  logic [QW-1:0]                                    idx,
  input  logic                                             inc_drop,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  dispatched,
  output logic [REGISTER_SIZE-1:0]                         dropped
);

  localparam logic [REGISTER_SIZE-1:0] ONE = {{(REGISTER_SIZE-1){1'b0}}, 1'b1};

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] r_disp;
  logic [REGISTER_SIZE-1:0]                       r_drop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_disp <= '0;
      r_drop <= '0;
    end else begin
      if (inc_dispatch) r_disp[idx] <= r_disp[idx] + ONE;
      if (inc_drop)     r_drop      <= r_drop + ONE;
    end
  end

  assign dispatched = r_disp;
  assign dropped    = r_drop;

endmodule

// File: rtl/transaction_dispatcher.sv
// Pops one packet per scheduler enable, presents it on a valid/ready port and
// pulses consumed once the transaction is accepted or dropped.
module transaction_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int PACKET_SIZE      = 64,
  parameter int REGISTER_SIZE    = 32,
  parameter int QW               = qid_width(NUMBER_OF_QUEUES)
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [QW-1:0]                                    id,
  input  logic                                             enable,
  output logic                                             ready,
  output logic                                             consumed,
  input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
  input  logic [NUMBER_OF_QUEUES-1:0][PACKET_SIZE-1:0]    queue_data,
  output logic [NUMBER_OF_QUEUES-1:0]                      pop,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic [PACKET_SIZE-1:0]                           m_data,
  output logic [QW-1:0]                                    m_qid,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  dispatched,
  output logic [REGISTER_SIZE-1:0]                         dropped,
  output logic                                             protocol_error
);

  dispatcher_state_t r_state, w_state_nxt;

  logic [QW-1:0]               r_qid;
  logic [PACKET_SIZE-1:0]      r_m_data;
  logic [QW-1:0]               r_m_qid;
  logic                        r_perr;
  logic                        w_id_empty;
  logic [NUMBER_OF_QUEUES-1:0] w_pop;
  logic                        w_inc_drop;
  logic                        w_inc_disp;
  logic                        w_perr_set;

  // Out-of-range ids (non-power-of-2 queue counts) behave like empty queues.
  assign w_id_empty = (int'(id) >= NUMBER_OF_QUEUES) || empty[id];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_inc_drop  = 1'b0;
    w_inc_disp  = 1'b0;
    w_perr_set  = enable && (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = w_id_empty ? ST_DONE : ST_FETCH;
          w_inc_drop  = w_id_empty;
        end
      end
      ST_FETCH: begin
        w_pop[r_qid] = 1'b1;
        w_state_nxt  = ST_SEND;
      end
      ST_SEND: begin
        if (m_ready) begin
          w_inc_disp  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_qid    <= '0;
      r_m_data <= '0;
      r_m_qid  <= '0;
      r_perr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && enable) r_qid <= id;
      // FWFT head is valid in the pop cycle, so capture alongside the strobe.
      if (r_state == ST_FETCH) begin
        r_m_data <= queue_data[r_qid];
        r_m_qid  <= r_qid;
      end
      if (w_perr_set) r_perr <= 1'b1;
    end
  end

  dispatch_stats #(
    .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
    .REGISTER_SIZE    (REGISTER_SIZE),
    .QW               (QW)
  ) u_stats (
    .clock        (clock),
    .reset        (reset),
    .inc_dispatch (w_inc_disp),
    .idx          (r_qid),
    .inc_drop     (w_inc_drop),
    .dispatched   (dispatched),
    .dropped      (dropped)
  );

  assign ready          = (r_state == ST_IDLE);
  assign consumed       = (r_state == ST_DONE);
  assign m_valid        = (r_state == ST_SEND);
  assign pop            = w_pop;
  assign m_data         = r_m_data;
  assign m_qid          = r_m_qid;
  assign protocol_error = r_perr;

endmodule

// File: tb/tb_transaction_dispatcher.sv
// Directed bench for transaction_dispatcher with a cycle-timed transaction model.
module tb_transaction_dispatcher;

  localparam int NQ = 4;
  localparam int PS = 64;
  localparam int RS = 32;

  logic                   clock;
  logic                   reset;
  logic [1:0]             id;
  logic                   enable;
  logic                   ready;
  logic                   consumed;
  logic [NQ-1:0]          empty;
  logic [NQ-1:0][PS-1:0]  queue_data;
  logic [NQ-1:0]          pop;
  logic                   m_valid;
  logic                   m_ready;
  logic [PS-1:0]          m_data;
  logic [1:0]             m_qid;
  logic [NQ-1:0][RS-1:0]  dispatched;
  logic [RS-1:0]          dropped;
  logic                   protocol_error;

  transaction_dispatcher #(
    .NUMBER_OF_QUEUES (NQ),
    .PACKET_SIZE      (PS),
    .REGISTER_SIZE    (RS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .id             (id),
    .enable         (enable),
    .ready          (ready),
    .consumed       (consumed),
    .empty          (empty),
    .queue_data     (queue_data),
    .pop            (pop),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_qid          (m_qid),
    .dispatched     (dispatched),
    .dropped        (dropped),
    .protocol_error (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: an enable seen in cycle T0 while idle pops at T0+1,
  // shows the packet from T0+2 until accepted at Ta, and consumed at Ta+1.
  // A drop shows consumed at T0+1. Counters reflect events one cycle later.
  int          cyc = 0;
  bit          mdl_active = 0;
  bit          mdl_dropped_txn = 0;
  int          t_en = 0;
  int          t_acc = -1;
  int          mdl_q = 0;
  logic [63:0] mdl_cap = '0;
  logic [63:0] mdl_mdata = '0;
  logic [1:0]  mdl_mqid = '0;
  logic [31:0] mdl_disp [NQ];
  logic [31:0] mdl_drop = '0;
  bit          mdl_perr = 0;
  int          pop_cnt = 0;
  int          cons_cnt = 0;

  always @(negedge clock) begin
    logic [NQ-1:0] exp_pop;
    logic          exp_valid;
    logic          exp_cons;
    cyc++;
    if (!reset) begin
      mdl_active = 0;
      t_acc      = -1;
      mdl_mdata  = '0;
      mdl_mqid   = '0;
      mdl_drop   = '0;
      mdl_perr   = 0;
      for (int q = 0; q < NQ; q++) mdl_disp[q] = '0;
    end
    exp_pop   = '0;
    exp_valid = 1'b0;
    exp_cons  = 1'b0;
    if (reset && mdl_active) begin
      if (mdl_dropped_txn) begin
        exp_cons = (cyc == t_en + 1);
      end else begin
        if (cyc == t_en + 1) begin
          exp_pop[mdl_q] = 1'b1;
          mdl_cap = queue_data[mdl_q];
        end
        if (cyc == t_en + 2) begin
          mdl_mdata = mdl_cap;
          mdl_mqid  = 2'(mdl_q);
        end
        exp_valid = (cyc >= t_en + 2) && (t_acc < 0);
        exp_cons  = (t_acc >= 0) && (cyc == t_acc + 1);
      end
    end
    chk("ready",    ready,    !mdl_active);
    chk("consumed", consumed, exp_cons);
    chk("pop",      pop,      exp_pop);
    chk("m_valid",  m_valid,  exp_valid);
    chk("m_data",   m_data,   mdl_mdata);
    chk("m_qid",    m_qid,    mdl_mqid);
    for (int q = 0; q < NQ; q++) chk($sformatf("dispatched%0d", q), dispatched[q], mdl_disp[q]);
    chk("dropped",  dropped,  mdl_drop);
    chk("protocol_error", protocol_error, mdl_perr);
    if (reset) begin
      if (exp_valid && m_ready) begin
        t_acc = cyc;
        mdl_disp[mdl_q] = mdl_disp[mdl_q] + 32'd1;
      end
      if (enable) begin
        if (mdl_active) begin
          mdl_perr = 1;
        end else begin
          mdl_active      = 1;
          t_en            = cyc;
          t_acc           = -1;
          mdl_q           = int'(id);
          mdl_dropped_txn = empty[id];
          if (empty[id]) mdl_drop = mdl_drop + 32'd1;
        end
      end else if (exp_cons) begin
        mdl_active = 0;
      end
    end
    pop_cnt  += $countones(pop);
    cons_cnt += int'(consumed);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int c0, p0, sent, sum;

  initial begin
    reset = 1'b0; enable = 1'b0; id = '0; empty = '1; queue_data = '0; m_ready = 1'b0;
    for (int q = 0; q < NQ; q++) mdl_disp[q] = '0;
    repeat (2) tick();
    @(negedge clock);
    chk("rst_ready", ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_dropped", dropped, 32'd0);
    tick(); reset = 1'b1;
    repeat (2) tick();

    // Basic dispatch from queue 2
    empty = 4'b1011; queue_data[2] = 64'hCAFE; id = 2'd2; enable = 1'b1; m_ready = 1'b1;
    tick(); enable = 1'b0;
    @(negedge clock); chk("cafe_pop_T1", pop, 4'b0100);
    tick(); @(negedge clock);
    chk("cafe_valid_T2", m_valid, 1'b1);
    chk("cafe_data_T2", m_data, 64'hCAFE);
    chk("cafe_qid_T2", m_qid, 2'd2);
    tick(); @(negedge clock); chk("cafe_consumed_T3", consumed, 1'b1);
    tick(); @(negedge clock);
    chk("cafe_ready_T4", ready, 1'b1);
    chk("cafe_disp2", dispatched[2], 32'd1);

    // Same transfer stalled five cycles by m_ready
    tick(); id = 2'd2; enable = 1'b1; m_ready = 1'b0;
    tick(); enable = 1'b0;
    tick(); queue_data[2] = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_data", m_data, 64'hCAFE);
      chk("stall_consumed", consumed, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clock); chk("stall_accept_consumed", consumed, 1'b0);
    tick(); m_ready = 1'b0;
    @(negedge clock); chk("stall_consumed_after", consumed, 1'b1);
    tick(); @(negedge clock); chk("stall_disp2", dispatched[2], 32'd2);

    // Enable to an empty queue is dropped
    tick(); empty = 4'b0010; id = 2'd1; enable = 1'b1;
    tick(); enable = 1'b0;
    @(negedge clock);
    chk("drop_pop", pop, 4'b0000);
    chk("drop_valid", m_valid, 1'b0);
    chk("drop_consumed_T1", consumed, 1'b1);
    tick(); @(negedge clock); chk("drop_count", dropped, 32'd1);

    // Enable while busy flags a protocol error but the transfer completes
    tick(); empty = 4'b0000; queue_data[3] = 64'h3333; id = 2'd3; enable = 1'b1; m_ready = 1'b0;
    c0 = cons_cnt;
    tick(); enable = 1'b0;
    tick(); enable = 1'b1; id = 2'd0;
    tick(); enable = 1'b0;
    @(negedge clock); chk("perr_set", protocol_error, 1'b1);
    repeat (2) tick();
    m_ready = 1'b1;
    tick(); m_ready = 1'b0;
    repeat (3) tick();
    chk("perr_single_consumed", cons_cnt - c0, 1);
    chk("perr_disp3", dispatched[3], 32'd1);
    chk("perr_sticky", protocol_error, 1'b1);

    // Reset in the middle of SEND
    id = 2'd0; queue_data[0] = 64'hABCD; enable = 1'b1; m_ready = 1'b0;
    tick(); enable = 1'b0;
    tick(); @(negedge clock); chk("rsend_valid", m_valid, 1'b1);
    tick(); reset = 1'b0; c0 = cons_cnt;
    @(negedge clock);
    chk("rsend_valid_low", m_valid, 1'b0);
    chk("rsend_disp2", dispatched[2], 32'd0);
    chk("rsend_perr", protocol_error, 1'b0);
    tick(); reset = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    chk("rsend_no_consumed", cons_cnt - c0, 0);
    chk("rsend_ready", ready, 1'b1);

    // Back-to-back traffic, 1000 packets across 4 queues
    m_ready = 1'b0; p0 = pop_cnt; c0 = cons_cnt; sent = 0;
    for (int k = 0; k < 20000 && (sent < 1000 || mdl_active || enable); k++) begin
      tick();
      for (int q = 0; q < NQ; q++) queue_data[q] = {$urandom, $urandom};
      m_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000 && !mdl_active) begin
        enable = 1'b1; id = 2'($urandom_range(0, 3)); sent++;
      end else begin
        enable = 1'b0;
      end
    end
    enable = 1'b0;
    tick();
    chk("b2b_drained", mdl_active, 1'b0);
    sum = 0;
    for (int q = 0; q < NQ; q++) sum += int'(dispatched[q]);
    chk("b2b_sum_dispatched", sum, 1000);
    chk("b2b_pops", pop_cnt - p0, 1000);
    chk("b2b_consumed", cons_cnt - c0, 1000);
    chk("b2b_dropped", dropped, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
